// File: rtl/dcache_write_buffer.sv
// Write-back buffer between the data cache and data memory.
// Absorbs dirty-line writebacks, drains them in order and serves refills from buffered lines.
module dcache_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [ADDR_W-1:0]          c_addr_i,
    input  logic [LINE_W-1:0]          c_data_i,
    input  logic                       c_enable_i,
    input  logic                       c_write_i,
    output logic                       c_ack_o,
    output logic [LINE_W-1:0]          c_data_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [LINE_W-1:0]          mem_data_o,
    output logic                       mem_enable_o,
    output logic                       mem_write_o,
    input  logic                       mem_ack_i,
    input  logic [LINE_W-1:0]          mem_data_i,
    output logic [$clog2(DEPTH+1)-1:0] wb_count_o,
    output logic                       wb_full_o,
    output logic                       wb_empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int LW = ADDR_W - 5;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_READ,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DEPTH-1:0]  r_valid;
    logic [LW-1:0]     r_line [DEPTH];
    logic [LINE_W-1:0] r_data [DEPTH];
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              r_rd_pend;
    logic [LW-1:0]     r_rd_line;
    logic              r_ack;
    logic [LINE_W-1:0] r_cdata;

    logic [LW-1:0]     w_req_line;
    logic              w_hit;
    logic [AW-1:0]     w_hit_idx;
    logic              w_coal;
    logic [AW-1:0]     w_coal_idx;
    logic              w_c_ack;
    logic              w_acc;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_push;
    logic              w_pop;

    assign w_req_line = c_addr_i[ADDR_W-1:5];
    assign w_c_ack    = r_ack | (r_state == S_RESP);
    assign w_acc      = c_enable_i & ~w_c_ack & ~r_rd_pend;
    assign w_wr_acc   = w_acc & c_write_i & (w_coal | (r_count != FULL_CNT));
    assign w_push     = w_wr_acc & ~w_coal;
    assign w_rd_acc   = w_acc & ~c_write_i;
    assign w_pop      = (r_state == S_DRAIN) & mem_ack_i;

    // Walk from head to tail so the newest matching entry is the last one seen.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_coal     = 1'b0;
        w_coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[r_head + AW'(i)] &&
                r_line[r_head + AW'(i)] == w_req_line) begin
                w_hit     = 1'b1;
                w_hit_idx = r_head + AW'(i);
                if (!(i == 0 && r_state == S_DRAIN)) begin
                    w_coal     = 1'b1;
                    w_coal_idx = r_head + AW'(i);
                end
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (r_rd_pend) begin
                    w_next = S_READ;
                end else if (r_count != '0) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {r_line[r_head], 5'b0};
                mem_data_o   = r_data[r_head];
                if (mem_ack_i) begin
                    w_next = S_IDLE;
                end
            end
            S_READ: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {r_rd_line, 5'b0};
                if (mem_ack_i) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_valid   <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_rd_pend <= 1'b0;
            r_rd_line <= '0;
            r_ack     <= 1'b0;
            r_cdata   <= '0;
        end else begin
            r_state <= w_next;
            r_ack   <= w_wr_acc | (w_rd_acc & w_hit);
            if (w_rd_acc & w_hit) begin
                r_cdata <= r_data[w_hit_idx];
            end else if (r_state == S_READ && mem_ack_i) begin
                r_cdata <= mem_data_i;
            end
            if (w_rd_acc & ~w_hit) begin
                r_rd_pend <= 1'b1;
                r_rd_line <= w_req_line;
            end else if (r_state == S_RESP) begin
                r_rd_pend <= 1'b0;
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Line storage carries no reset; validity alone decides what is live.
    always_ff @(posedge clk_i) begin
        if (w_wr_acc && !rst_i) begin
            if (w_coal) begin
                r_data[w_coal_idx] <= c_data_i;
            end else begin
                r_data[r_tail] <= c_data_i;
                r_line[r_tail] <= w_req_line;
            end
        end
    end

    assign c_ack_o    = w_c_ack;
    assign c_data_o   = r_cdata;
    assign wb_count_o = r_count;
    assign wb_full_o  = (r_count == FULL_CNT);
    assign wb_empty_o = (r_count == '0);

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Bench for dcache_write_buffer: directed scenarios plus random traffic
// checked against a flat "latest value per line" view and a memory model.
module tb_dcache_write_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int CW     = $clog2(DEPTH+1);

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [ADDR_W-1:0] c_addr_i;
    logic [LINE_W-1:0] c_data_i;
    logic              c_enable_i;
    logic              c_write_i;
    logic              c_ack_o;
    logic [LINE_W-1:0] c_data_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_i;
    logic [CW-1:0]     wb_count_o;
    logic              wb_full_o;
    logic              wb_empty_o;

    dcache_write_buffer #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .c_addr_i    (c_addr_i),
        .c_data_i    (c_data_i),
        .c_enable_i  (c_enable_i),
        .c_write_i   (c_write_i),
        .c_ack_o     (c_ack_o),
        .c_data_o    (c_data_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_enable_o(mem_enable_o),
        .mem_write_o (mem_write_o),
        .mem_ack_i   (mem_ack_i),
        .mem_data_i  (mem_data_i),
        .wb_count_o  (wb_count_o),
        .wb_full_o   (wb_full_o),
        .wb_empty_o  (wb_empty_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model and the cache's view of what each line should read back.
    logic [LINE_W-1:0] mem_arr [int];
    logic [LINE_W-1:0] ref_mem [int];
    int                log_addr [$];
    bit                log_w [$];
    logic [LINE_W-1:0] log_d [$];
    int                pop_cyc = -1;
    int                lat = 0;
    bit                mem_block = 1'b0;
    bit                mem_manual = 1'b0;

    function automatic logic [LINE_W-1:0] dflt(input int ln);
        return {8{32'(ln) ^ 32'hA5A5_0000}};
    endfunction

    function automatic logic [LINE_W-1:0] mem_rd(input int ln);
        return mem_arr.exists(ln) ? mem_arr[ln] : dflt(ln);
    endfunction

    function automatic logic [LINE_W-1:0] ref_rd(input int ln);
        return ref_mem.exists(ln) ? ref_mem[ln] : dflt(ln);
    endfunction

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        int wcnt;
        wcnt       = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (mem_manual) begin
                wcnt = 0;
            end else if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                wcnt      = 0;
            end else if (mem_enable_o && !mem_block) begin
                if (wcnt >= lat) begin
                    mem_ack_i = 1'b1;
                    wcnt      = 0;
                    chk("mem_addr_align", mem_addr_o[4:0], 0);
                    log_addr.push_back(int'(mem_addr_o));
                    log_w.push_back(mem_write_o);
                    log_d.push_back(mem_write_o ? mem_data_o : '0);
                    if (mem_write_o) begin
                        mem_arr[int'(mem_addr_o >> 5)] = mem_data_o;
                        if (pop_cyc < 0) pop_cyc = cyc + 1;
                    end else begin
                        mem_data_i = mem_rd(int'(mem_addr_o >> 5));
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_w.delete();
        log_d.delete();
    endtask

    // Issue one cache request, wait for its ack, then idle one cycle.
    task automatic req(input bit wr, input logic [31:0] a,
                       input logic [LINE_W-1:0] d,
                       output logic [LINE_W-1:0] rd, output int n);
        c_enable_i = 1'b1;
        c_write_i  = wr;
        c_addr_i   = a;
        c_data_i   = d;
        n          = 0;
        rd         = '0;
        while (n < 300) begin
            @(posedge clk_i);
            #1;
            n++;
            if (c_ack_o) break;
        end
        if (!c_ack_o) chk("req_timeout", 0, 1);
        rd         = c_data_o;
        c_enable_i = 1'b0;
        c_write_i  = 1'b0;
        @(posedge clk_i);
        #1;
        chk("ack_pulse", c_ack_o, 0);
    endtask

    task automatic cwr(input logic [31:0] a, input logic [LINE_W-1:0] d,
                       output int n);
        logic [LINE_W-1:0] tmp;
        req(1'b1, a, d, tmp, n);
        ref_mem[int'(a >> 5)] = d;
    endtask

    task automatic crd(input logic [31:0] a, output logic [LINE_W-1:0] d,
                       output int n);
        req(1'b0, a, '0, d, n);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((!wb_empty_o || mem_enable_o) && k < 500) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        chk({tag, "_drained"}, wb_empty_o, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [LINE_W-1:0] d;
        logic [LINE_W-1:0] got;
        logic [31:0]       a;
        int                n;
        int                ack_cyc;
        int                k;

        rst_i      = 1'b1;
        c_enable_i = 1'b0;
        c_write_i  = 1'b0;
        c_addr_i   = '0;
        c_data_i   = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ack", c_ack_o, 0);
        chk("rst_men", mem_enable_o, 0);
        chk("rst_cnt", wb_count_o, 0);
        chk("rst_empty", wb_empty_o, 1);
        chk("rst_full", wb_full_o, 0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Single writeback drained to memory.
        clear_log();
        mem_block = 1'b1;
        lat       = 3;
        d         = rnd_line();
        cwr(32'h100, d, n);
        chk("t1_ack_lat", n, 1);
        chk("t1_cnt", wb_count_o, 1);
        chk("t1_men", mem_enable_o, 1);
        chk("t1_mwr", mem_write_o, 1);
        chk("t1_maddr", mem_addr_o, 32'h100);
        chk("t1_mdata", mem_data_o, d);
        mem_block = 1'b0;
        drain("t1");
        chk("t1_nlog", log_addr.size(), 1);
        if (log_addr.size() == 1) chk("t1_logd", log_d[0], d);

        // Coalescing behind an in-flight drain.
        clear_log();
        mem_block = 1'b1;
        lat       = 0;
        begin
            logic [LINE_W-1:0] p, x, z;
            p = rnd_line();
            x = rnd_line();
            z = rnd_line();
            cwr(32'h200, p, n);
            cwr(32'h240, x, n);
            cwr(32'h244, z, n);
            chk("t2_cnt", wb_count_o, 2);
            mem_block = 1'b0;
            drain("t2");
            chk("t2_nlog", log_addr.size(), 2);
            if (log_addr.size() == 2) begin
                chk("t2_addr0", log_addr[0], 32'h200);
                chk("t2_data0", log_d[0], p);
                chk("t2_addr1", log_addr[1], 32'h240);
                chk("t2_data1", log_d[1], z);
            end
        end

        // Full buffer stalls the fifth writeback until a pop.
        clear_log();
        mem_block = 1'b1;
        lat       = 2;
        for (int i = 0; i < 4; i++) begin
            cwr(32'h700 + 32'(i * 32), rnd_line(), n);
            chk("t3_fill_lat", n, 1);
        end
        chk("t3_full", wb_full_o, 1);
        chk("t3_cnt4", wb_count_o, 4);
        d          = rnd_line();
        c_enable_i = 1'b1;
        c_write_i  = 1'b1;
        c_addr_i   = 32'h780;
        c_data_i   = d;
        repeat (4) @(posedge clk_i);
        #1;
        chk("t3_noack", c_ack_o, 0);
        pop_cyc   = -1;
        mem_block = 1'b0;
        ack_cyc   = -1;
        k         = 0;
        while (!c_ack_o && k < 50) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        if (c_ack_o) ack_cyc = cyc;
        chk("t3_ack_timing", ack_cyc, pop_cyc + 1);
        chk("t3_cnt_hold", wb_count_o, 4);
        c_enable_i = 1'b0;
        c_write_i  = 1'b0;
        ref_mem[32'h780 >> 5] = d;
        @(posedge clk_i);
        #1;
        drain("t3");
        chk("t3_nlog", log_addr.size(), 5);

        // Refill hit on a buffered line.
        clear_log();
        mem_block = 1'b1;
        lat       = 0;
        d         = rnd_line();
        cwr(32'h300, d, n);
        crd(32'h30C, got, n);
        chk("t4_data", got, d);
        chk("t4_lat", n, 1);
        chk("t4_no_read", mem_write_o, 1);
        mem_block = 1'b0;
        drain("t4");
        chk("t4_nlog", log_addr.size(), 1);

        // Read miss slots in between two drains.
        clear_log();
        mem_block = 1'b1;
        d         = rnd_line();
        mem_arr[32'h400 >> 5] = d;
        ref_mem[32'h400 >> 5] = d;
        cwr(32'h500, rnd_line(), n);
        cwr(32'h520, rnd_line(), n);
        fork
            crd(32'h400, got, n);
            begin
                repeat (3) @(posedge clk_i);
                #1;
                mem_block = 1'b0;
            end
        join
        chk("t5_data", got, d);
        drain("t5");
        chk("t5_nlog", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            chk("t5_a0", log_addr[0], 32'h500);
            chk("t5_w0", log_w[0], 1);
            chk("t5_a1", log_addr[1], 32'h400);
            chk("t5_w1", log_w[1], 0);
            chk("t5_a2", log_addr[2], 32'h520);
            chk("t5_w2", log_w[2], 1);
        end

        // Reset during a drain; the late memory ack is ignored.
        mem_manual = 1'b1;
        mem_ack_i  = 1'b0;
        cwr(32'h600, rnd_line(), n);
        chk("t6_draining", mem_enable_o, 1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("t6_men", mem_enable_o, 0);
        chk("t6_cnt", wb_count_o, 0);
        chk("t6_ack", c_ack_o, 0);
        mem_ack_i = 1'b1;
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("t6_late_cnt", wb_count_o, 0);
        chk("t6_late_men", mem_enable_o, 0);
        chk("t6_late_empty", wb_empty_o, 1);
        ref_mem[32'h600 >> 5] = mem_rd(32'h600 >> 5);
        mem_manual = 1'b0;

        // Random traffic over a small set of lines.
        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(0, 3);
            a   = 32'h1000 + 32'($urandom_range(0, 7) << 5)
                + 32'($urandom_range(0, 31));
            if ($urandom_range(0, 99) < 60) begin
                cwr(a, rnd_line(), n);
            end else begin
                crd(a, got, n);
                chk("rnd_read", got, ref_rd(int'(a >> 5)));
            end
            chk("rnd_cnt_le", wb_count_o <= CW'(DEPTH), 1);
            chk("rnd_full", wb_full_o, wb_count_o == CW'(DEPTH));
            chk("rnd_empty", wb_empty_o, wb_count_o == '0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_i);
                #1;
            end
        end
        drain("rnd");
        for (int i = 0; i < 8; i++) begin
            k = (32'h1000 >> 5) + i;
            chk("rnd_final_mem", mem_rd(k), ref_rd(k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
